// File: rtl/data_mem_resp.sv
// Data-memory responder for the core load/store port.
// One request in flight, fixed wait states, byte/half/word lanes.
module data_mem_resp #(
  parameter int A_WIDTH    = 32,
  parameter int D_WIDTH    = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [D_WIDTH-1:0] resp_rdata,
  output logic               resp_err
);

  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, nstate;
  logic [3:0] cnt;

  logic               l_we, l_uns;
  logic [A_WIDTH-1:0] l_addr;
  logic [D_WIDTH-1:0] l_wdata;
  logic [1:0]         l_size;

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic acc, go;
  assign acc        = req_valid & req_ready;
  assign req_ready  = (state == IDLE) & ~rst;
  assign resp_valid = (state == RESP);

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (acc) nstate = (LAT == 4'd0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) nstate = RESP;
      RESP:    if (resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign go = (nstate == RESP) && (state != RESP);

  // With zero wait states the access edge is the acceptance edge,
  // so the fields come straight from the request port.
  logic               a_we, a_uns;
  logic [A_WIDTH-1:0] a_addr;
  logic [D_WIDTH-1:0] a_wdata;
  logic [1:0]         a_size;

  always_comb begin
    if (state == IDLE) begin
      a_we    = req_we;
      a_uns   = req_unsigned;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_size  = req_size;
    end else begin
      a_we    = l_we;
      a_uns   = l_uns;
      a_addr  = l_addr;
      a_wdata = l_wdata;
      a_size  = l_size;
    end
  end

  logic                  err;
  logic [DEPTH_LOG2-1:0] idx;
  logic [D_WIDTH-1:0]    word, shifted, ld, wd;
  logic [3:0]            be;

  assign idx  = a_addr[DEPTH_LOG2+1:2];
  assign word = mem[idx];

  always_comb begin
    err = (a_size == 2'b11)
        | ((a_size == 2'b01) & a_addr[0])
        | ((a_size == 2'b10) & (a_addr[1:0] != 2'b00))
        | ((a_addr >> (DEPTH_LOG2 + 2)) != '0);
  end

  always_comb begin
    shifted = word >> {a_addr[1:0], 3'b000};
    ld      = word;
    be      = 4'b1111;
    wd      = a_wdata;
    unique case (a_size)
      2'b00: begin
        ld = a_uns ? {24'd0, shifted[7:0]}
                   : {{24{shifted[7]}}, shifted[7:0]};
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        ld = a_uns ? {16'd0, shifted[15:0]}
                   : {{16{shifted[15]}}, shifted[15:0]};
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_wdata[15:0]}};
      end
      default: begin
        ld = word;
        be = 4'b1111;
        wd = a_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      l_we       <= 1'b0;
      l_uns      <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_size     <= '0;
    end else begin
      state <= nstate;
      if (acc) begin
        l_we    <= req_we;
        l_uns   <= req_unsigned;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_size  <= req_size;
        cnt     <= LAT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (go) begin
        resp_err   <= err;
        resp_rdata <= (err | a_we) ? '0 : ld;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (go & a_we & ~err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: lanes, errors,
// backpressure, zero-latency instance and async reset.
module tb_data_mem_resp;

  logic        clk = 0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        z_valid, z_ready, z_we, z_uns;
  logic [31:0] z_addr, z_wdata;
  logic [1:0]  z_size;
  logic        z_rvalid, z_rready, z_err;
  logic [31:0] z_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.LATENCY(2)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_resp #(.LATENCY(0)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_addr(z_addr),
    .req_wdata(z_wdata), .req_size(z_size),
    .req_unsigned(z_uns),
    .resp_valid(z_rvalid), .resp_ready(z_rready),
    .resp_rdata(z_rdata), .resp_err(z_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz,
                       input logic uns);
    @(negedge clk);
    req_valid    = 1;
    req_we       = we;
    req_addr     = a;
    req_wdata    = d;
    req_size     = sz;
    req_unsigned = uns;
  endtask

  task automatic wait_accept(input string tag);
    int k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk({tag, "_accept_timeout"}, 32'(k), 32'd0);
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
  endtask

  task automatic finish_resp;
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  task automatic xact(input string tag, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    issue(we, a, d, sz, uns);
    wait_accept(tag);
    wait_resp(n);
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_rdata"}, resp_rdata, exp_d);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_e});
    finish_resp();
  endtask

  initial begin
    int n;
    logic [31:0] hold_d;
    logic        hold_e;

    rst = 1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    req_size = 0; req_unsigned = 0; resp_ready = 0;
    z_valid = 0; z_we = 0; z_addr = 0; z_wdata = 0;
    z_size = 0; z_uns = 0; z_rready = 0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    xact("sw10", 1, 32'h10, 32'h12345678, 2'b10, 0, 32'h0, 0);
    xact("lw10", 0, 32'h10, 32'h0, 2'b10, 0, 32'h12345678, 0);

    xact("lb13", 0, 32'h13, 32'h0, 2'b00, 0, 32'h00000012, 0);
    xact("sb11", 1, 32'h11, 32'hAAAAAA80, 2'b00, 0, 32'h0, 0);
    xact("lb11", 0, 32'h11, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0);
    xact("lbu11", 0, 32'h11, 32'h0, 2'b00, 1, 32'h00000080, 0);
    xact("lw10b", 0, 32'h10, 32'h0, 2'b10, 0, 32'h12348078, 0);

    xact("sh12", 1, 32'h12, 32'h5555BEEF, 2'b01, 0, 32'h0, 0);
    xact("lh12", 0, 32'h12, 32'h0, 2'b01, 0, 32'hFFFFBEEF, 0);
    xact("lhu12", 0, 32'h12, 32'h0, 2'b01, 1, 32'h0000BEEF, 0);
    xact("lw12", 0, 32'h12, 32'h0, 2'b10, 0, 32'h0, 1);
    xact("sw12", 1, 32'h12, 32'hDEADBEEF, 2'b10, 0, 32'h0, 1);
    xact("lw10c", 0, 32'h10, 32'h0, 2'b10, 0, 32'hBEEF8078, 0);
    xact("lh11", 0, 32'h11, 32'h0, 2'b01, 0, 32'h0, 1);
    xact("size3", 0, 32'h10, 32'h0, 2'b11, 0, 32'h0, 1);

    // Backpressure with a second request waiting
    issue(0, 32'h10, 32'h0, 2'b10, 0);
    wait_accept("bp");
    wait_resp(n);
    chk("bp_lat", 32'(n), 32'd3);
    chk("bp_rdata", resp_rdata, 32'hBEEF8078);
    hold_d = resp_rdata;
    hold_e = resp_err;
    req_valid = 1; req_we = 0; req_addr = 32'h12;
    req_size = 2'b01; req_unsigned = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata_hold", resp_rdata, hold_d);
      chk("bp_err_hold", {31'd0, resp_err}, {31'd0, hold_e});
      chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    end
    finish_resp();
    @(negedge clk);
    chk("bp_second_ready", {31'd0, req_ready}, 32'd1);
    wait_accept("bp2");
    wait_resp(n);
    chk("bp2_lat", 32'(n), 32'd3);
    chk("bp2_rdata", resp_rdata, 32'h0000BEEF);
    finish_resp();

    xact("oor", 0, 32'h1000, 32'h0, 2'b10, 0, 32'h0, 1);
    xact("lastw", 1, 32'hFFC, 32'h01020304, 2'b10, 0, 32'h0, 0);

    // Zero wait-state instance
    @(negedge clk);
    z_valid = 1; z_we = 1; z_addr = 32'hFFC;
    z_wdata = 32'hCAFEF00D; z_size = 2'b10; z_uns = 0;
    chk("z_ready", {31'd0, z_ready}, 32'd1);
    @(posedge clk);
    #1 z_valid = 0;
    @(negedge clk);
    chk("z_sw_valid", {31'd0, z_rvalid}, 32'd1);
    chk("z_sw_err", {31'd0, z_err}, 32'd0);
    z_rready = 1;
    @(posedge clk);
    #1 z_rready = 0;
    @(negedge clk);
    z_valid = 1; z_we = 0;
    @(posedge clk);
    #1 z_valid = 0;
    @(negedge clk);
    chk("z_lw_valid", {31'd0, z_rvalid}, 32'd1);
    chk("z_lw_rdata", z_rdata, 32'hCAFEF00D);
    chk("z_lw_err", {31'd0, z_err}, 32'd0);
    z_rready = 1;
    @(posedge clk);
    #1 z_rready = 0;

    // Reset mid-transaction
    xact("sw20", 1, 32'h20, 32'hAAAA5555, 2'b10, 0, 32'h0, 0);
    xact("lw20", 0, 32'h20, 32'h0, 2'b10, 0, 32'hAAAA5555, 0);
    issue(1, 32'h20, 32'h11111111, 2'b10, 0);
    wait_accept("sw20rst");
    @(negedge clk);
    rst = 1;
    #1;
    chk("rstw_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_ready", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 0;
    xact("lw20r", 0, 32'h20, 32'h0, 2'b10, 0, 32'hAAAA5555, 0);

    issue(0, 32'h12, 32'h0, 2'b10, 0);
    wait_accept("rstr");
    wait_resp(n);
    chk("rstr_err_before", {31'd0, resp_err}, 32'd1);
    rst = 1;
    #1;
    chk("rstr_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstr_err", {31'd0, resp_err}, 32'd0);
    chk("rstr_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 0;
    xact("post", 0, 32'h10, 32'h0, 2'b10, 0, 32'hBEEF8078, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
